// File: rtl/mdu_pkg.sv
// Shared MDU definitions: 4-bit EX opcode encodings, controller states and
// accumulate modes used by mdu_ctrl and mdu_mul.
package mdu_pkg;

  typedef enum logic [3:0] {
    OP_NOP   = 4'h0,
    OP_MULT  = 4'h1,
    OP_MULTU = 4'h2,
    OP_DIV   = 4'h3,
    OP_DIVU  = 4'h4,
    OP_MTHI  = 4'h5,
    OP_MTLO  = 4'h6,
    OP_MFHI  = 4'h7,
    OP_MFLO  = 4'h8,
    OP_MADD  = 4'h9,
    OP_MADDU = 4'hA,
    OP_MSUB  = 4'hB,
    OP_MSUBU = 4'hC
  } mdu_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL1,
    S_MUL2,
    S_DIV_BUSY
  } mdu_state_e;

  typedef enum logic [1:0] {
    ACC_NONE,
    ACC_ADD,
    ACC_SUB
  } mdu_acc_e;

endpackage

// File: rtl/mdu_mul.sv
// Two-stage 32x32 multiplier: operands captured on load, 64-bit product
// registered on step.
module mdu_mul
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        step_i,
  input  logic        signed_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [63:0] prod_o
);

  logic [31:0] a_q, b_q;
  logic        sgn_q;
  logic [63:0] prod_q, prod_d;
  logic [63:0] a_ext, b_ext;

  // Low 64 bits of the extended product are exact for both signednesses.
  always_comb begin
    a_ext  = sgn_q ? {{32{a_q[31]}}, a_q} : {32'b0, a_q};
    b_ext  = sgn_q ? {{32{b_q[31]}}, b_q} : {32'b0, b_q};
    prod_d = a_ext * b_ext;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      a_q    <= '0;
      b_q    <= '0;
      sgn_q  <= 1'b0;
      prod_q <= '0;
    end else begin
      if (load_i) begin
        a_q   <= a_i;
        b_q   <= b_i;
        sgn_q <= signed_i;
      end
      if (step_i) prod_q <= prod_d;
    end
  end

  assign prod_o = prod_q;

endmodule

// File: rtl/mdu_ctrl.sv
// MDU controller: HI/LO registers, 2-stage multiply, external divider handshake.
// Define MDU_MADD_EN to enable MADD/MADDU/MSUB/MSUBU accumulate ops.
module mdu_ctrl
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_stall,
  input  logic        d_stall,
  input  logic        flush_i,
  input  logic        valid_i,
  input  logic [3:0]  op_i,
  input  logic [31:0] rs_i,
  input  logic [31:0] rt_i,
  output logic        div_start_o,
  output logic        div_signed_o,
  output logic        div_annul_o,
  output logic [31:0] div_op1_o,
  output logic [31:0] div_op2_o,
  input  logic [63:0] div_result_i,
  input  logic        div_ready_i,
  output logic        stall_req_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic [31:0] mf_data_o
);

  mdu_state_e  state_q, state_d;
  mdu_acc_e    acc_q, acc_d, acc_sel;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] op1_q, op1_d, op2_q, op2_d;
  logic        sgn_q, sgn_d;
  logic        frz, issue_mul, issue_div, mul_signed;
  logic        mul_load, mul_step, stall_c, annul_c;
  logic [63:0] prod, hilo_new;

  assign frz = i_stall | d_stall;

  always_comb begin
    issue_mul  = 1'b0;
    issue_div  = 1'b0;
    mul_signed = 1'b0;
    acc_sel    = ACC_NONE;
    case (op_i)
      OP_MULT:           begin issue_mul = 1'b1; mul_signed = 1'b1; end
      OP_MULTU:          issue_mul = 1'b1;
      OP_DIV, OP_DIVU:   issue_div = 1'b1;
`ifdef MDU_MADD_EN
      OP_MADD:  begin issue_mul = 1'b1; mul_signed = 1'b1; acc_sel = ACC_ADD; end
      OP_MADDU: begin issue_mul = 1'b1; acc_sel = ACC_ADD; end
      OP_MSUB:  begin issue_mul = 1'b1; mul_signed = 1'b1; acc_sel = ACC_SUB; end
      OP_MSUBU: begin issue_mul = 1'b1; acc_sel = ACC_SUB; end
`endif
      default: ;
    endcase
  end

  always_comb begin
    case (acc_q)
      ACC_ADD: hilo_new = {hi_q, lo_q} + prod;
      ACC_SUB: hilo_new = {hi_q, lo_q} - prod;
      default: hilo_new = prod;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    sgn_d    = sgn_q;
    mul_load = 1'b0;
    mul_step = 1'b0;
    stall_c  = 1'b0;
    annul_c  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (valid_i && !flush_i) begin
          if (issue_mul) begin
            stall_c  = 1'b1;
            mul_load = 1'b1;
            acc_d    = acc_sel;
            state_d  = S_MUL1;
          end else if (issue_div) begin
            stall_c = 1'b1;
            op1_d   = rs_i;
            op2_d   = rt_i;
            sgn_d   = (op_i == OP_DIV);
            state_d = S_DIV_BUSY;
          end else if (op_i == OP_MTHI) begin
            hi_d = rs_i;
          end else if (op_i == OP_MTLO) begin
            lo_d = rs_i;
          end
        end
      end
      S_MUL1: begin
        stall_c = 1'b1;
        if (flush_i) begin
          state_d = S_IDLE;
        end else begin
          mul_step = 1'b1;
          state_d  = S_MUL2;
        end
      end
      S_MUL2: begin
        state_d = S_IDLE;
        if (!flush_i) {hi_d, lo_d} = hilo_new;
      end
      S_DIV_BUSY: begin
        stall_c = !div_ready_i;
        if (flush_i) begin
          annul_c = 1'b1;
          state_d = S_IDLE;
        end else if (div_ready_i) begin
          {hi_d, lo_d} = div_result_i;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A frozen pipeline holds everything; reset still wins over the freeze.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      acc_q   <= ACC_NONE;
      hi_q    <= '0;
      lo_q    <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      sgn_q   <= 1'b0;
    end else if (!frz) begin
      state_q <= state_d;
      acc_q   <= acc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      sgn_q   <= sgn_d;
    end
  end

  mdu_mul u_mul (
    .clk      (clk),
    .rst      (rst),
    .load_i   (mul_load & ~frz),
    .step_i   (mul_step & ~frz),
    .signed_i (mul_signed),
    .a_i      (rs_i),
    .b_i      (rt_i),
    .prod_o   (prod)
  );

  assign div_start_o  = (state_q == S_DIV_BUSY);
  assign div_signed_o = sgn_q;
  assign div_op1_o    = op1_q;
  assign div_op2_o    = op2_q;
  assign div_annul_o  = rst & ~frz & annul_c;
  assign stall_req_o  = rst & stall_c;
  assign hi_o         = hi_q;
  assign lo_o         = lo_q;
  assign mf_data_o    = !valid_i           ? '0   :
                        (op_i == OP_MFHI)  ? hi_q :
                        (op_i == OP_MFLO)  ? lo_q : '0;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed cases plus randomized ops against
// an arithmetic HI/LO reference; honours MDU_MADD_EN like the design.
module tb_mdu_ctrl;

  localparam logic [3:0] C_NOP = 4'h0, C_MULT = 4'h1, C_MULTU = 4'h2, C_DIV = 4'h3,
                         C_DIVU = 4'h4, C_MTHI = 4'h5, C_MTLO = 4'h6, C_MFHI = 4'h7,
                         C_MFLO = 4'h8, C_MADD = 4'h9, C_MADDU = 4'hA, C_MSUB = 4'hB,
                         C_MSUBU = 4'hC;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_stall = 1'b0, d_stall = 1'b0, flush = 1'b0, valid = 1'b0;
  logic [3:0]  op = 4'h0;
  logic [31:0] rs = '0, rt = '0;
  logic [63:0] div_res = '0;
  logic        div_ready = 1'b0;
  logic        div_start, div_signed, div_annul, stall_req;
  logic [31:0] div_op1, div_op2, hi, lo, mf_data;

  int unsigned n_chk = 0, n_fail = 0;
  logic [31:0] m_hi = '0, m_lo = '0;

  always #10 clk = ~clk;

  mdu_ctrl dut (
    .clk(clk), .rst(rst), .i_stall(i_stall), .d_stall(d_stall), .flush_i(flush),
    .valid_i(valid), .op_i(op), .rs_i(rs), .rt_i(rt),
    .div_start_o(div_start), .div_signed_o(div_signed), .div_annul_o(div_annul),
    .div_op1_o(div_op1), .div_op2_o(div_op2), .div_result_i(div_res),
    .div_ready_i(div_ready), .stall_req_o(stall_req), .hi_o(hi), .lo_o(lo),
    .mf_data_o(mf_data)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_chk++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] mul_model(input logic [3:0] o, input logic [31:0] a,
                                            input logic [31:0] b, input logic [63:0] acc);
    longint      sp;
    logic [63:0] up;
    sp = longint'($signed(a)) * longint'($signed(b));
    up = {32'b0, a} * {32'b0, b};
    case (o)
      C_MULT:  return sp;
      C_MULTU: return up;
      C_MADD:  return acc + sp;
      C_MADDU: return acc + up;
      C_MSUB:  return acc - sp;
      C_MSUBU: return acc - up;
      default: return acc;
    endcase
  endfunction

  // Divider behaviour: {remainder, quotient}, zero for divide-by-zero.
  function automatic logic [63:0] div_model(input logic sgn, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 0) return 64'd0;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'b0, a});
      sb = longint'({32'b0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic do_mul(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int nfrz);
    logic [63:0] want;
    want = mul_model(o, a, b, {m_hi, m_lo});
    valid = 1'b1; op = o; rs = a; rt = b;
    #1 chk("mul_issue_stall", 64'(stall_req), 64'd1);
    tick();
    valid = 1'b0; op = C_NOP; rs = $urandom; rt = $urandom;
    for (int i = 0; i < nfrz; i++) begin
      d_stall = 1'b1;
      #1 chk("mul_frozen_stall", 64'(stall_req), 64'd1);
      chk("mul_frozen_hilo", {hi, lo}, {m_hi, m_lo});
      tick();
    end
    d_stall = 1'b0;
    #1 chk("mul1_stall", 64'(stall_req), 64'd1);
    tick();
    chk("mul2_stall", 64'(stall_req), 64'd0);
    chk("mul2_hilo_old", {hi, lo}, {m_hi, m_lo});
    tick();
    chk("mul_result", {hi, lo}, want);
    {m_hi, m_lo} = want;
  endtask

  task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input int lat);
    logic [63:0] want;
    want = div_model(sgn, a, b);
    valid = 1'b1; op = sgn ? C_DIV : C_DIVU; rs = a; rt = b;
    #1 chk("div_issue_stall", 64'(stall_req), 64'd1);
    chk("div_start_idle", 64'(div_start), 64'd0);
    tick();
    valid = 1'b0; op = C_NOP; rs = $urandom; rt = $urandom;
    #1 chk("div_start", 64'(div_start), 64'd1);
    chk("div_signed", 64'(div_signed), 64'(sgn));
    chk("div_busy_stall", 64'(stall_req), 64'd1);
    for (int i = 1; i < lat; i++) begin
      tick();
      chk("div_start_hold", 64'(div_start), 64'd1);
    end
    chk("div_ops", {div_op1, div_op2}, {a, b});
    div_ready = 1'b1; div_res = want;
    #1 chk("div_ready_stall", 64'(stall_req), 64'd0);
    tick();
    div_ready = 1'b0; div_res = '0;
    #1 chk("div_start_drop", 64'(div_start), 64'd0);
    chk("div_result", {hi, lo}, want);
    {m_hi, m_lo} = want;
  endtask

  task automatic do_mt(input logic to_hi, input logic [31:0] v, input logic flsh);
    valid = 1'b1; op = to_hi ? C_MTHI : C_MTLO; rs = v; flush = flsh;
    #1 chk("mt_stall", 64'(stall_req), 64'd0);
    tick();
    valid = 1'b0; flush = 1'b0; op = C_NOP;
    if (!flsh) begin
      if (to_hi) m_hi = v;
      else       m_lo = v;
    end
    #1 chk("mt_hilo", {hi, lo}, {m_hi, m_lo});
  endtask

  task automatic chk_mf();
    valid = 1'b1; op = C_MFHI;
    #1 chk("mfhi", 64'(mf_data), 64'(m_hi));
    op = C_MFLO;
    #1 chk("mflo", 64'(mf_data), 64'(m_lo));
    op = C_NOP;
    #1 chk("mf_other", 64'(mf_data), 64'd0);
    valid = 1'b0;
  endtask

  task automatic do_noop(input logic [3:0] o);
    valid = 1'b1; op = o; rs = $urandom; rt = $urandom;
    #1 chk("noop_stall", 64'(stall_req), 64'd0);
    tick();
    valid = 1'b0; op = C_NOP;
    #1 chk("noop_idle", 64'(stall_req), 64'd0);
    chk("noop_hilo", {hi, lo}, {m_hi, m_lo});
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] edges [5];
    edges = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
    if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    rst = 1'b0;
    tick(); tick();
    chk("rst_hilo", {hi, lo}, 64'd0);
    chk("rst_divops", {div_op1, div_op2}, 64'd0);
    chk("rst_flags", {61'd0, div_start, div_annul, div_signed}, 64'd0);
    chk("rst_stall", 64'(stall_req), 64'd0);
    rst = 1'b1;
    tick();

    // MULT -1 * 2
    do_mul(C_MULT, 32'hFFFFFFFF, 32'd2, 0);
    chk("mult_neg_const", {hi, lo}, 64'hFFFFFFFF_FFFFFFFE);
    chk_mf();

    // DIVU 100/7, divider ready after 34 cycles
    do_div(1'b0, 32'd100, 32'd7, 34);
    chk("divu_const", {hi, lo}, {32'd2, 32'd14});

    // DIV -7/0
    do_div(1'b1, 32'hFFFFFFF9, 32'd0, 3);
    chk("div0_const", {hi, lo}, 64'd0);

    // MT writes, flush in IDLE suppresses MT and issue
    do_mt(1'b1, 32'h12345678, 1'b0);
    do_mt(1'b0, 32'h9ABCDEF0, 1'b0);
    do_mt(1'b0, 32'hCAFEF00D, 1'b1);
    valid = 1'b1; op = C_MULT; rs = 32'd3; rt = 32'd5; flush = 1'b1;
    #1 chk("flush_idle_stall", 64'(stall_req), 64'd0);
    tick();
    valid = 1'b0; flush = 1'b0; op = C_NOP;
    #1 chk("flush_idle_noissue", 64'(stall_req), 64'd0);
    tick(); tick();
    chk("flush_idle_hilo", {hi, lo}, {m_hi, m_lo});

    // flush during DIV_BUSY, with a frozen flush first and an ignored MTHI
    valid = 1'b1; op = C_DIVU; rs = 32'd1000; rt = 32'd3;
    tick();
    op = C_MTHI; rs = 32'hDEADBEEF;
    tick();
    i_stall = 1'b1; flush = 1'b1;
    #1 chk("annul_frozen", 64'(div_annul), 64'd0);
    tick();
    i_stall = 1'b0;
    chk("div_busy_after_frz", 64'(div_start), 64'd1);
    #1 chk("annul_pulse", 64'(div_annul), 64'd1);
    tick();
    flush = 1'b0; valid = 1'b0; op = C_NOP;
    #1 chk("annul_drop", 64'(div_annul), 64'd0);
    chk("flush_div_idle", {62'd0, div_start, stall_req}, 64'd0);
    chk("flush_div_hilo", {hi, lo}, {m_hi, m_lo});

    // flush during MUL1
    valid = 1'b1; op = C_MULTU; rs = 32'd77; rt = 32'd99;
    tick();
    valid = 1'b0; op = C_NOP; flush = 1'b1;
    tick();
    flush = 1'b0;
    tick(); tick();
    chk("flush_mul_hilo", {hi, lo}, {m_hi, m_lo});

    // 5-cycle freeze mid-multiply
    do_mul(C_MULTU, 32'hABCD1234, 32'h00FF00FF, 5);

    // unknown and no-op codes
    do_noop(C_NOP);
    do_noop(4'hD);
    do_noop(4'hF);

    // accumulate ops
    do_mt(1'b1, 32'h0, 1'b0);
    do_mt(1'b0, 32'hFFFFFFFF, 1'b0);
`ifdef MDU_MADD_EN
    do_mul(C_MADD, 32'd1, 32'd1, 0);
    chk("madd_const", {hi, lo}, {32'd1, 32'd0});
    do_mul(C_MSUBU, 32'd2, 32'd3, 1);
`else
    do_noop(C_MADD);
    chk("madd_disabled", {hi, lo}, {32'd0, 32'hFFFFFFFF});
    do_noop(C_MSUBU);
`endif

    // randomized mix
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 7))
        0: do_mul(C_MULT, pick(), pick(), int'($urandom_range(0, 2)));
        1: do_mul(C_MULTU, pick(), pick(), int'($urandom_range(0, 2)));
        2: do_div(1'b1, pick(), ($urandom_range(0, 4) == 0) ? 32'd0 : pick(),
                  int'($urandom_range(1, 6)));
        3: do_div(1'b0, pick(), ($urandom_range(0, 4) == 0) ? 32'd0 : pick(),
                  int'($urandom_range(1, 6)));
        4: do_mt(1'b1, pick(), 1'($urandom_range(0, 1)));
        5: do_mt(1'b0, pick(), 1'($urandom_range(0, 1)));
`ifdef MDU_MADD_EN
        6: do_mul(4'(C_MADD + 4'($urandom_range(0, 3))), pick(), pick(),
                  int'($urandom_range(0, 1)));
`else
        6: do_noop(4'(C_MADD + 4'($urandom_range(0, 3))));
`endif
        default: chk_mf();
      endcase
    end

    // reset mid-multiply while frozen
    valid = 1'b1; op = C_MULT; rs = 32'd6; rt = 32'd7;
    tick();
    valid = 1'b0; op = C_NOP;
    rst = 1'b0; i_stall = 1'b1;
    tick();
    rst = 1'b1; i_stall = 1'b0;
    #1 chk("rst_mid_stall", 64'(stall_req), 64'd0);
    chk("rst_mid_hilo", {hi, lo}, 64'd0);
    tick(); tick();
    chk("rst_mid_nowrite", {hi, lo}, 64'd0);
    m_hi = '0; m_lo = '0;

    // reset mid-divide
    valid = 1'b1; op = C_DIV; rs = 32'd50; rt = 32'd5;
    tick();
    valid = 1'b0; op = C_NOP;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("rst_div_flags", {62'd0, div_start, div_signed}, 64'd0);
    chk("rst_div_ops", {div_op1, div_op2}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
